pipelined_prefix_adder: RTL and testbench
=========================================

PIPELINED_PREFIX_ADDER -- requirements
Module: pipelined_prefix_adder

Interface
REQ-001 SHALL have parameter WIDTH, default 32: operand width in bits; legal values are powers of two, 4..128.
REQ-002 SHALL have parameter REG_EVERY, default 2: a pipeline register is inserted after every REG_EVERY prefix levels; legal values are 1..log2(WIDTH).
REQ-003 SHALL have parameter TAG_W, default 4: width of the sideband tag.
REQ-004 SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-005 SHALL have port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-006 SHALL have port in_valid, input, 1 bit: operands are presented this cycle.
REQ-007 SHALL have port in_ready, output, 1 bit: the block accepts operands this cycle.
REQ-008 SHALL have port op_a, input, WIDTH bits: operand A.
REQ-009 SHALL have port op_b, input, WIDTH bits: operand B.
REQ-010 SHALL have port cin, input, 1 bit: carry-in; used only when sub=0.
REQ-011 SHALL have port sub, input, 1 bit: 1 selects A-B, 0 selects A+B+cin.
REQ-012 SHALL have port tag_in, input, TAG_W bits: sideband field carried alongside the operation.
REQ-013 SHALL have port out_valid, output, 1 bit: a result is presented.
REQ-014 SHALL have port out_ready, input, 1 bit: the downstream accepts the result.
REQ-015 SHALL have port sum, output, WIDTH bits: the result.
REQ-016 SHALL have port cout, output, 1 bit: carry out of the MSB.
REQ-017 SHALL have port ovf, output, 1 bit: signed overflow.
REQ-018 SHALL have port zero, output, 1 bit: asserted when sum==0.
REQ-019 SHALL have port neg, output, 1 bit: equal to sum[WIDTH-1].
REQ-020 SHALL have port tag_out, output, TAG_W bits: the tag_in captured with this result.

Function
REQ-021 SHALL compute B' = sub ? ~op_b : op_b and C0 = sub ? 1 : cin; on input acceptance it SHALL register per-bit g=A&B', p=A^B', C0, and tag into stage 0.
REQ-022 SHALL resolve carries with a Kogge-Stone prefix network of L=log2(WIDTH) levels; at level k, bit i combines with bit i-2^k when i>=2^k, and passes through unchanged otherwise.
REQ-023 SHALL fold C0 in as the generate term below bit 0, so that carry into bit i = G[i-1:0] | (P[i-1:0] & C0).
REQ-024 SHALL register after every REG_EVERY levels and always after level L; the number of prefix register stages S = ceil(L/REG_EVERY).
REQ-025 SHALL have latency 1+S cycles from acceptance to out_valid when there are no stalls (4 cycles for the defaults).
REQ-026 SHALL compute sum[i] = p[i]^c[i], cout = c[WIDTH], and ovf = c[WIDTH]^c[WIDTH-1] combinationally from the final register stage.
REQ-027 SHALL carry a valid bit with each stage; one operation is accepted when in_valid && in_ready, and one is retired when out_valid && out_ready.
REQ-028 SHALL drive in_ready = !(out_valid && !out_ready); while in_ready=0, all stages hold their contents (global stall), and bubbles are not compressed.
REQ-029 SHALL hold sum, cout, ovf, zero, neg, and tag_out stable while out_valid=1 and out_ready=0.
REQ-030 SHALL sustain a throughput of one operation per cycle when out_ready is held at 1; simultaneous accept and retire in the same cycle is legal.
REQ-031 SHALL ignore op_a, op_b, cin, sub, and tag_in when in_valid=0; the stage valid bit loads 0 in that case.

Reset
REQ-032 SHALL, on rst_n low, asynchronously clear all stage valid bits, making out_valid=0 and in_ready=1 immediately.
REQ-033 SHALL reset sum, cout, ovf, neg, and tag_out to 0, and zero to 1 (it reflects sum=0).
REQ-034 SHALL, when reset asserts mid-operation, discard all in-flight operations; no result from before reset appears after rst_n releases.
REQ-035 SHALL accept input in the first rising clk edge after rst_n deasserts.

Verification
REQ-036 Add (defaults): A=0xFFFFFFFF, B=0x00000001, cin=0, sub=0 -> 4 cycles later sum=0, cout=1, zero=1, ovf=0.
REQ-037 Subtract: A=0x80000000, B=1, sub=1 -> sum=0x7FFFFFFF, cout=1, ovf=1, neg=0.
REQ-038 Back-to-back: 8 ops with tags 0..7, out_ready=1 -> results on 8 consecutive cycles, tags in order, each sum matching the reference model.
REQ-039 Backpressure: out_ready=0 for 5 cycles while results are pending -> in_ready=0, outputs frozen; on release, no op is lost or duplicated.
REQ-040 Reset mid-flight: 3 ops in flight, rst_n pulsed low -> out_valid=0 at once, and no stale result after release.
REQ-041 Parameter sweep: WIDTH in {4,16,64} and REG_EVERY in {1,L} with random operands -> all results match a+b+cin / a-b with the latency from REQ-025.

Source files
------------

// File: rtl/pipelined_prefix_adder.sv
// Pipelined Kogge-Stone adder/subtractor with valid/ready flow control.
// Register cut after every REG_EVERY prefix levels and after the last.
module pipelined_prefix_adder #(
  parameter int WIDTH     = 32,
  parameter int REG_EVERY = 2,
  parameter int TAG_W     = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] op_a,
  input  logic [WIDTH-1:0] op_b,
  input  logic             cin,
  input  logic             sub,
  input  logic [TAG_W-1:0] tag_in,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf,
  output logic             zero,
  output logic             neg,
  output logic [TAG_W-1:0] tag_out
);

  localparam int L = $clog2(WIDTH);

  logic [WIDTH-1:0] w_bx;
  logic             w_c0;
  logic             w_en;
  logic [WIDTH-1:0] r_g;
  logic [WIDTH-1:0] r_p;
  logic             r_c0;
  logic             r_v;
  logic [TAG_W-1:0] r_tag;
  logic [WIDTH-1:0] w_g0;

  assign in_ready = !(out_valid && !out_ready);
  assign w_en     = in_ready;
  assign w_bx     = sub ? ~op_b : op_b;
  assign w_c0     = sub | cin;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_v   <= 1'b0;
      r_g   <= '0;
      r_p   <= '0;
      r_c0  <= 1'b0;
      r_tag <= '0;
    end else if (w_en) begin
      r_v <= in_valid;
      if (in_valid) begin
        r_g   <= op_a & w_bx;
        r_p   <= op_a ^ w_bx;
        r_c0  <= w_c0;
        r_tag <= tag_in;
      end
    end
  end

  // C0 folded into bit 0: group G[i:0] is then the carry into bit i+1
  assign w_g0 = {r_g[WIDTH-1:1], r_g[0] | (r_p[0] & r_c0)};

  for (genvar k = 0; k < L; k++) begin : g_lvl
    localparam int D   = 1 << k;
    localparam bit CUT = ((k + 1) % REG_EVERY == 0) || (k + 1 == L);

    logic [WIDTH-1:0] w_gi, w_pi, w_oi;
    logic [WIDTH-1:0] w_gn, w_gq, w_oq;
    logic [TAG_W-1:0] w_ti, w_tq;
    logic             w_ci, w_vi, w_cq, w_vq;

    if (k == 0) begin : g_src
      assign w_gi = w_g0;
      assign w_pi = r_p;
      assign w_oi = r_p;
      assign w_ci = r_c0;
      assign w_vi = r_v;
      assign w_ti = r_tag;
    end else begin : g_src
      assign w_gi = g_lvl[k-1].w_gq;
      assign w_pi = g_lvl[k-1].g_pp.w_pq;
      assign w_oi = g_lvl[k-1].w_oq;
      assign w_ci = g_lvl[k-1].w_cq;
      assign w_vi = g_lvl[k-1].w_vq;
      assign w_ti = g_lvl[k-1].w_tq;
    end

    for (genvar i = 0; i < WIDTH; i++) begin : g_bit
      if (i >= D) begin : g_c
        assign w_gn[i] = w_gi[i] | (w_pi[i] & w_gi[i-D]);
      end else begin : g_t
        assign w_gn[i] = w_gi[i];
      end
    end

    // group propagate is not needed past the last level
    if (k < L - 1) begin : g_pp
      logic [WIDTH-1:0] w_pn, w_pq;
      for (genvar i = 0; i < WIDTH; i++) begin : g_bit
        if (i >= D) begin : g_c
          assign w_pn[i] = w_pi[i] & w_pi[i-D];
        end else begin : g_t
          assign w_pn[i] = w_pi[i];
        end
      end
      if (CUT) begin : g_r
        logic [WIDTH-1:0] r_pq;
        always_ff @(posedge clk or negedge rst_n) begin
          if (!rst_n)    r_pq <= '0;
          else if (w_en) r_pq <= w_pn;
        end
        assign w_pq = r_pq;
      end else begin : g_w
        assign w_pq = w_pn;
      end
    end

    if (CUT) begin : g_r
      logic [WIDTH-1:0] r_gq, r_oq;
      logic [TAG_W-1:0] r_tq;
      logic             r_cq, r_vq;
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          r_gq <= '0;
          r_oq <= '0;
          r_tq <= '0;
          r_cq <= 1'b0;
          r_vq <= 1'b0;
        end else if (w_en) begin
          r_gq <= w_gn;
          r_oq <= w_oi;
          r_tq <= w_ti;
          r_cq <= w_ci;
          r_vq <= w_vi;
        end
      end
      assign w_gq = r_gq;
      assign w_oq = r_oq;
      assign w_tq = r_tq;
      assign w_cq = r_cq;
      assign w_vq = r_vq;
    end else begin : g_w
      assign w_gq = w_gn;
      assign w_oq = w_oi;
      assign w_tq = w_ti;
      assign w_cq = w_ci;
      assign w_vq = w_vi;
    end
  end

  logic [WIDTH-1:0] w_gf;
  logic [WIDTH-1:0] w_of;
  logic             w_cf;

  assign w_gf      = g_lvl[L-1].w_gq;
  assign w_of      = g_lvl[L-1].w_oq;
  assign w_cf      = g_lvl[L-1].w_cq;
  assign out_valid = g_lvl[L-1].w_vq;
  assign tag_out   = g_lvl[L-1].w_tq;

  assign sum  = w_of ^ {w_gf[WIDTH-2:0], w_cf};
  assign cout = w_gf[WIDTH-1];
  assign ovf  = w_gf[WIDTH-1] ^ w_gf[WIDTH-2];
  assign zero = (sum == '0);
  assign neg  = sum[WIDTH-1];

endmodule

// File: tb/tb_pipelined_prefix_adder.sv
// Bench for pipelined_prefix_adder: arithmetic model with queues,
// directed vectors, backpressure, reset and a width/cut sweep.
module tb_pipelined_prefix_adder;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid, in_ready;
  logic [31:0] op_a, op_b;
  logic        cin, sub;
  logic [3:0]  tag_in;
  logic        out_valid, out_ready;
  logic [31:0] sum;
  logic        cout, ovf, zero, neg;
  logic [3:0]  tag_out;

  logic [63:0] sw_a, sw_b;
  logic        sw_cin, sw_sub, sw_valid;
  logic [3:0]  sw_tag;
  logic        r4, v4, c4, o4, z4, n4;
  logic [3:0]  s4, t4;
  logic        r16, v16, c16, o16, z16, n16;
  logic [15:0] s16;
  logic [3:0]  t16;
  logic        r64, v64, c64, o64, z64, n64;
  logic [63:0] s64;
  logic [3:0]  t64;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int acc_n = 0;
  int ret_n = 0;
  logic rec = 1'b0;
  int nrec = 0;
  int rec_cyc [8];
  logic [3:0] rec_tag [8];

  typedef struct {
    logic [63:0] s;
    logic        co;
    logic        ov;
    logic [3:0]  t;
    int          c;
  } exp_t;

  exp_t q[$];
  exp_t q4[$];
  exp_t q16[$];
  exp_t q64[$];

  always #5 clk = ~clk;

  pipelined_prefix_adder u_dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .op_a(op_a), .op_b(op_b), .cin(cin), .sub(sub),
    .tag_in(tag_in), .out_valid(out_valid),
    .out_ready(out_ready), .sum(sum), .cout(cout),
    .ovf(ovf), .zero(zero), .neg(neg), .tag_out(tag_out)
  );

  pipelined_prefix_adder #(.WIDTH(4), .REG_EVERY(1), .TAG_W(4)) u_w4 (
    .clk(clk), .rst_n(rst_n),
    .in_valid(sw_valid), .in_ready(r4),
    .op_a(sw_a[3:0]), .op_b(sw_b[3:0]), .cin(sw_cin), .sub(sw_sub),
    .tag_in(sw_tag), .out_valid(v4), .out_ready(1'b1),
    .sum(s4), .cout(c4), .ovf(o4), .zero(z4), .neg(n4), .tag_out(t4)
  );

  pipelined_prefix_adder #(.WIDTH(16), .REG_EVERY(1), .TAG_W(4)) u_w16 (
    .clk(clk), .rst_n(rst_n),
    .in_valid(sw_valid), .in_ready(r16),
    .op_a(sw_a[15:0]), .op_b(sw_b[15:0]), .cin(sw_cin), .sub(sw_sub),
    .tag_in(sw_tag), .out_valid(v16), .out_ready(1'b1),
    .sum(s16), .cout(c16), .ovf(o16), .zero(z16), .neg(n16), .tag_out(t16)
  );

  pipelined_prefix_adder #(.WIDTH(64), .REG_EVERY(6), .TAG_W(4)) u_w64 (
    .clk(clk), .rst_n(rst_n),
    .in_valid(sw_valid), .in_ready(r64),
    .op_a(sw_a), .op_b(sw_b), .cin(sw_cin), .sub(sw_sub),
    .tag_in(sw_tag), .out_valid(v64), .out_ready(1'b1),
    .sum(s64), .cout(c64), .ovf(o64), .zero(z64), .neg(n64), .tag_out(t64)
  );

  // plain w-bit arithmetic: A+B+cin or A-B, carry, signed overflow
  function automatic exp_t model(input int w, input logic [63:0] a, b,
                                 input logic ci, sb, input logic [3:0] t,
                                 input int c);
    exp_t e;
    logic [64:0] m, r, aa, bb;
    m  = (65'd1 << w) - 65'd1;
    aa = {1'b0, a} & m;
    bb = {1'b0, b} & m;
    if (sb) begin
      r    = (aa - bb) & m;
      e.co = (aa >= bb);
      e.ov = (aa[w-1] != bb[w-1]) && (r[w-1] != aa[w-1]);
    end else begin
      r    = aa + bb + 65'(ci);
      e.co = r[w];
      r    = r & m;
      e.ov = (aa[w-1] == bb[w-1]) && (r[w-1] != aa[w-1]);
    end
    e.s = r[63:0];
    e.t = t;
    e.c = c;
    return e;
  endfunction

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic spur(input string nm);
    checks++;
    errors++;
    $display("FAIL %s: got unexpected out_valid, expected none", nm);
  endtask

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (rst_n && in_valid && in_ready) begin
      q.push_back(model(32, 64'(op_a), 64'(op_b), cin, sub, tag_in, cyc));
      acc_n <= acc_n + 1;
    end
    if (rst_n && sw_valid) begin
      q4.push_back(model(4, sw_a, sw_b, sw_cin, sw_sub, sw_tag, cyc));
      q16.push_back(model(16, sw_a, sw_b, sw_cin, sw_sub, sw_tag, cyc));
      q64.push_back(model(64, sw_a, sw_b, sw_cin, sw_sub, sw_tag, cyc));
    end
  end

  always @(negedge clk) begin
    exp_t e;
    if (rst_n) begin
      chk("in_ready", in_ready, !(out_valid && !out_ready));
      if (out_valid) begin
        if (q.size() == 0) spur("main");
        else begin
          e = q[0];
          chk("sum", sum, e.s);
          chk("cout", cout, e.co);
          chk("ovf", ovf, e.ov);
          chk("zero", zero, e.s == 64'd0);
          chk("neg", neg, e.s[31]);
          chk("tag", tag_out, e.t);
          if (out_ready) begin
            void'(q.pop_front());
            ret_n <= ret_n + 1;
            if (rec && nrec < 8) begin
              rec_cyc[nrec] = cyc;
              rec_tag[nrec] = tag_out;
              nrec++;
            end
          end
        end
      end
      if (v4) begin
        if (q4.size() == 0) spur("w4");
        else begin
          e = q4.pop_front();
          chk("w4_sum", s4, e.s);
          chk("w4_cout", c4, e.co);
          chk("w4_ovf", o4, e.ov);
          chk("w4_zero", z4, e.s == 64'd0);
          chk("w4_neg", n4, e.s[3]);
          chk("w4_tag", t4, e.t);
          chk("w4_lat", cyc - e.c, 3);
          chk("w4_rdy", r4, 1);
        end
      end
      if (v16) begin
        if (q16.size() == 0) spur("w16");
        else begin
          e = q16.pop_front();
          chk("w16_sum", s16, e.s);
          chk("w16_cout", c16, e.co);
          chk("w16_ovf", o16, e.ov);
          chk("w16_zero", z16, e.s == 64'd0);
          chk("w16_neg", n16, e.s[15]);
          chk("w16_tag", t16, e.t);
          chk("w16_lat", cyc - e.c, 5);
          chk("w16_rdy", r16, 1);
        end
      end
      if (v64) begin
        if (q64.size() == 0) spur("w64");
        else begin
          e = q64.pop_front();
          chk("w64_sum", s64, e.s);
          chk("w64_cout", c64, e.co);
          chk("w64_ovf", o64, e.ov);
          chk("w64_zero", z64, e.s == 64'd0);
          chk("w64_neg", n64, e.s[63]);
          chk("w64_tag", t64, e.t);
          chk("w64_lat", cyc - e.c, 2);
          chk("w64_rdy", r64, 1);
        end
      end
    end
  end

  task automatic send(input logic [31:0] a, b, input logic ci, sb,
                      input logic [3:0] t, output int tries);
    logic ok;
    op_a     = a;
    op_b     = b;
    cin      = ci;
    sub      = sb;
    tag_in   = t;
    in_valid = 1'b1;
    tries    = 0;
    ok       = 1'b0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      ok = in_ready;
      tries++;
      @(posedge clk);
      #1;
      if (ok) break;
    end
    if (!ok) begin
      checks++;
      errors++;
      $display("FAIL send_timeout: got no accept, expected accept");
    end
  endtask

  task automatic single(input logic [31:0] a, b, input logic ci, sb,
                        input logic [3:0] t, input logic [31:0] xs,
                        input logic xc, xo);
    int n, lat;
    send(a, b, ci, sb, t, n);
    in_valid = 1'b0;
    lat = 1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (out_valid) break;
      @(posedge clk);
      lat++;
    end
    chk("lit_lat", lat, 4);
    chk("lit_sum", sum, xs);
    chk("lit_cout", cout, xc);
    chk("lit_ovf", ovf, xo);
    chk("lit_zero", zero, xs == 32'd0);
    chk("lit_neg", neg, xs[31]);
    chk("lit_tag", tag_out, t);
    @(posedge clk);
    #1;
  endtask

  logic [31:0] va [8] = '{32'h0000_0001, 32'hFFFF_FFFF, 32'h1234_5678,
                          32'h8000_0000, 32'h0F0F_0F0F, 32'h7FFF_FFFF,
                          32'hDEAD_BEEF, 32'h0000_0000};
  logic [31:0] vb [8] = '{32'h0000_0002, 32'hFFFF_FFFF, 32'h8765_4321,
                          32'h8000_0000, 32'hF0F0_F0F0, 32'h0000_0001,
                          32'h0BAD_F00D, 32'h0000_0001};
  logic [7:0] vs = 8'b1010_0110;

  initial begin
    int n, tot, stale, a0, r0;
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    op_a      = '0;
    op_b      = '0;
    cin       = 1'b0;
    sub       = 1'b0;
    tag_in    = '0;
    out_ready = 1'b1;
    sw_valid  = 1'b0;
    sw_a      = '0;
    sw_b      = '0;
    sw_cin    = 1'b0;
    sw_sub    = 1'b0;
    sw_tag    = '0;
    #12;
    chk("rst_valid", out_valid, 0);
    chk("rst_ready", in_ready, 1);
    chk("rst_sum", sum, 0);
    chk("rst_cout", cout, 0);
    chk("rst_ovf", ovf, 0);
    chk("rst_zero", zero, 1);
    chk("rst_neg", neg, 0);
    chk("rst_tag", tag_out, 0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    send(32'h0000_0000, 32'h0000_0000, 1'b0, 1'b0, 4'd0, n);
    in_valid = 1'b0;
    chk("first_accept", n, 1);
    repeat (6) @(posedge clk);
    #1;

    single(32'hFFFF_FFFF, 32'h1, 1'b0, 1'b0, 4'd3, 32'h0, 1'b1, 1'b0);
    single(32'h8000_0000, 32'h1, 1'b0, 1'b1, 4'd5,
           32'h7FFF_FFFF, 1'b1, 1'b1);
    single(32'h7FFF_FFFF, 32'h0, 1'b1, 1'b0, 4'd6,
           32'h8000_0000, 1'b0, 1'b1);
    single(32'h5, 32'h7, 1'b0, 1'b1, 4'd2, 32'hFFFF_FFFE, 1'b0, 1'b0);
    single(32'h0, 32'h0, 1'b1, 1'b1, 4'd4, 32'h0, 1'b1, 1'b0);

    nrec = 0;
    rec  = 1'b1;
    tot  = 0;
    for (int i = 0; i < 8; i++) begin
      send(va[i], vb[i], 1'(i), vs[i], 4'(i), n);
      tot += n;
    end
    in_valid = 1'b0;
    for (int i = 0; i < 20 && nrec < 8; i++) @(posedge clk);
    rec = 1'b0;
    chk("b2b_tries", tot, 8);
    chk("b2b_count", nrec, 8);
    for (int i = 0; i < nrec; i++) begin
      chk("b2b_tag", rec_tag[i], 4'(i));
      if (i > 0) chk("b2b_gap", rec_cyc[i] - rec_cyc[i-1], 1);
    end
    #1;

    a0 = acc_n;
    r0 = ret_n;
    send(32'd10, 32'd20, 1'b0, 1'b0, 4'd10, n);
    send(32'd7, 32'd9, 1'b0, 1'b1, 4'd11, n);
    send(32'hFFFF_FFFF, 32'd3, 1'b1, 1'b0, 4'd12, n);
    in_valid  = 1'b0;
    out_ready = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (out_valid) break;
    end
    op_a     = 32'd100;
    op_b     = 32'd1;
    tag_in   = 4'd9;
    in_valid = 1'b1;
    repeat (5) begin
      @(negedge clk);
      chk("bp_ready", in_ready, 0);
      chk("bp_valid", out_valid, 1);
      chk("bp_sum", sum, 32'd30);
      chk("bp_tag", tag_out, 4'd10);
    end
    @(posedge clk);
    #1;
    out_ready = 1'b1;
    send(32'd100, 32'd1, 1'b0, 1'b0, 4'd9, n);
    in_valid = 1'b0;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if (q.size() == 0 && !out_valid) break;
    end
    @(posedge clk);
    #1;
    chk("bp_acc", acc_n - a0, 4);
    chk("bp_ret", ret_n - r0, 4);
    chk("bp_drain", q.size(), 0);

    send(32'd1, 32'd1, 1'b0, 1'b0, 4'd1, n);
    send(32'd2, 32'd2, 1'b0, 1'b0, 4'd2, n);
    send(32'd3, 32'd3, 1'b0, 1'b0, 4'd3, n);
    in_valid = 1'b0;
    @(posedge clk);
    #1;
    chk("rst_pre", out_valid, 1);
    rst_n = 1'b0;
    q.delete();
    #1;
    chk("rst_mid_valid", out_valid, 0);
    chk("rst_mid_ready", in_ready, 1);
    chk("rst_mid_zero", zero, 1);
    chk("rst_mid_tag", tag_out, 0);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    stale = 0;
    repeat (12) begin
      @(negedge clk);
      if (out_valid) stale++;
    end
    chk("no_stale", stale, 0);
    @(posedge clk);
    #1;

    for (int i = 0; i < 40; i++) begin
      sw_a   = {$urandom, $urandom};
      sw_b   = {$urandom, $urandom};
      sw_cin = 1'($urandom);
      sw_sub = 1'($urandom);
      sw_tag = 4'(i);
      if (i == 0) begin
        sw_a   = '1;
        sw_b   = 64'd1;
        sw_cin = 1'b0;
        sw_sub = 1'b0;
      end else if (i == 1) begin
        sw_a   = 64'd0;
        sw_b   = 64'd1;
        sw_sub = 1'b1;
      end
      sw_valid = 1'b1;
      @(posedge clk);
      #1;
    end
    sw_valid = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    chk("w4_drain", q4.size(), 0);
    chk("w16_drain", q16.size(), 0);
    chk("w64_drain", q64.size(), 0);
    chk("main_drain", q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #50000;
    $display("FAIL watchdog: got no finish, expected finish");
    $fatal(1);
  end

endmodule
